// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM pipeline stage: FSM state, result-select codes,
// and the request / MEM-WB field bundles.
package mem_stage_pkg;

  typedef enum logic {
    MS_IDLE = 1'b0,
    MS_WAIT = 1'b1
  } mem_state_t;

  localparam logic [1:0] RS_ALU = 2'b00;
  localparam logic [1:0] RS_MEM = 2'b01;
  localparam logic [1:0] RS_PC4 = 2'b10;

  // Everything the stage needs to finish an access once the inputs are frozen.
  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] wr_data;
    logic [31:0] pc_plus4;
    logic [4:0]  write_addr;
    logic        reg_write;
    logic [1:0]  result_src;
    logic        we;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [31:0] pc_plus4;
    logic [4:0]  write_addr;
    logic        reg_write;
    logic [1:0]  result_src;
  } mem_wb_t;

  function automatic logic is_mem_op(input logic mem_write, input logic [1:0] result_src);
    return mem_write | (result_src == RS_MEM);
  endfunction

endpackage

// File: rtl/mem_wb_register.sv
// MEM/WB pipeline register: loads the next fields or a bubble every cycle.
module mem_wb_register
  import mem_stage_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    bubble_i,
  input  mem_wb_t d_i,
  output mem_wb_t q_o
);

  mem_wb_t wb_q;

  always_ff @(posedge clk) begin
    if (reset)         wb_q <= '0;
    else if (bubble_i) wb_q <= '0;
    else               wb_q <= d_i;
  end

  assign q_o = wb_q;

endmodule

// File: rtl/memory_stage.sv
// MEM stage: drives the data-memory handshake, stalls upstream while waiting,
// aborts after MAX_WAIT wait cycles, and feeds the MEM/WB register + result mux.
module memory_stage
  import mem_stage_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_result_m,
  input  logic [31:0] wr_data_m,
  input  logic [31:0] pc_plus4_m,
  input  logic [4:0]  write_addr_m,
  input  logic        reg_write_m,
  input  logic [1:0]  result_src_m,
  input  logic        mem_write_m,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_m,
  output logic [31:0] alu_result_w,
  output logic [31:0] read_data_w,
  output logic [31:0] pc_plus4_w,
  output logic [4:0]  write_addr_w,
  output logic        reg_write_w,
  output logic [1:0]  result_src_w,
  output logic [31:0] result_w,
  output logic        mem_timeout
);

  localparam int            CW      = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

  mem_state_t    state_q;
  logic [CW-1:0] cnt_q;
  mem_req_t      hold_q;
  logic          timeout_q;

  mem_req_t req_m, cur;
  logic     mem_op_m, in_wait, complete, abort;
  mem_wb_t  wb_d, wb_q;

  always_comb begin
    req_m            = '0;
    req_m.alu_result = alu_result_m;
    req_m.wr_data    = wr_data_m;
    req_m.pc_plus4   = pc_plus4_m;
    req_m.write_addr = write_addr_m;
    req_m.reg_write  = reg_write_m;
    req_m.result_src = result_src_m;
    req_m.we         = mem_write_m;
  end

  assign mem_op_m = is_mem_op(mem_write_m, result_src_m);
  assign in_wait  = (state_q == MS_WAIT);

  // While waiting the upstream registers are frozen, but the held copy is
  // authoritative so the bus stays stable regardless of what the inputs do.
  assign cur        = in_wait ? hold_q : req_m;
  assign dmem_req   = in_wait | mem_op_m;
  assign dmem_we    = cur.we;
  assign dmem_addr  = {cur.alu_result[31:2], 2'b00};
  assign dmem_wdata = cur.wr_data;

  assign complete = dmem_req & dmem_ack;
  assign abort    = in_wait & ~dmem_ack & (cnt_q == MAX_CNT);
  assign stall_m  = dmem_req & ~dmem_ack & ~abort;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= MS_IDLE;
      cnt_q     <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        MS_IDLE: begin
          if (mem_op_m) begin
            hold_q <= req_m;
            if (!dmem_ack) begin
              state_q <= MS_WAIT;
              cnt_q   <= CW'(1);
            end
          end
        end
        MS_WAIT: begin
          if (dmem_ack) begin
            state_q <= MS_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == MAX_CNT) begin
            state_q   <= MS_IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= MS_IDLE;
      endcase
    end
  end

  // Stores (including store+load-select) and aborts write back no memory data.
  always_comb begin
    wb_d            = '0;
    wb_d.alu_result = cur.alu_result;
    wb_d.pc_plus4   = cur.pc_plus4;
    wb_d.write_addr = cur.write_addr;
    wb_d.result_src = cur.result_src;
    wb_d.reg_write  = cur.reg_write & ~abort;
    wb_d.read_data  = (complete && !cur.we) ? dmem_rdata : 32'h0;
  end

  mem_wb_register u_mem_wb (
    .clk      (clk),
    .reset    (reset),
    .bubble_i (stall_m),
    .d_i      (wb_d),
    .q_o      (wb_q)
  );

  assign alu_result_w = wb_q.alu_result;
  assign read_data_w  = wb_q.read_data;
  assign pc_plus4_w   = wb_q.pc_plus4;
  assign write_addr_w = wb_q.write_addr;
  assign reg_write_w  = wb_q.reg_write;
  assign result_src_w = wb_q.result_src;
  assign mem_timeout  = timeout_q;

  always_comb begin
    case (result_src_w)
      RS_MEM:  result_w = read_data_w;
      RS_PC4:  result_w = pc_plus4_w;
      default: result_w = alu_result_w;
    endcase
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: single-cycle vector table plus hand-written
// wait / timeout / reset / back-to-back sequences (MAX_WAIT = 4).
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_result_m, wr_data_m, pc_plus4_m;
  logic [4:0]  write_addr_m;
  logic        reg_write_m, mem_write_m;
  logic [1:0]  result_src_m;
  logic        dmem_req, dmem_we, dmem_ack, stall_m, reg_write_w, mem_timeout;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] alu_result_w, read_data_w, pc_plus4_w, result_w;
  logic [4:0]  write_addr_w;
  logic [1:0]  result_src_w;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  memory_stage #(.MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .alu_result_m(alu_result_m), .wr_data_m(wr_data_m), .pc_plus4_m(pc_plus4_m),
    .write_addr_m(write_addr_m), .reg_write_m(reg_write_m),
    .result_src_m(result_src_m), .mem_write_m(mem_write_m),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall_m(stall_m),
    .alu_result_w(alu_result_w), .read_data_w(read_data_w), .pc_plus4_w(pc_plus4_w),
    .write_addr_w(write_addr_w), .reg_write_w(reg_write_w),
    .result_src_w(result_src_w), .result_w(result_w), .mem_timeout(mem_timeout)
  );

  typedef struct {
    logic [31:0] alu, wd, pc4;
    logic [4:0]  wa;
    logic        rw;
    logic [1:0]  rs;
    logic        mw, ack;
    logic [31:0] rd;
    logic        e_req, e_we;
    logic [31:0] e_addr, e_res, e_rdw;
    logic        e_rw;
    logic [4:0]  e_wa;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc4,
                       input logic [4:0] wa, input logic rw, input logic [1:0] rs,
                       input logic mw, input logic ack, input logic [31:0] rd);
    alu_result_m = alu; wr_data_m = wd; pc_plus4_m = pc4; write_addr_m = wa;
    reg_write_m = rw; result_src_m = rs; mem_write_m = mw; dmem_ack = ack; dmem_rdata = rd;
  endtask

  task automatic nop();
    drive(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0);
  endtask

  // Advance one clock; sample registered outputs just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wb_zero(input string tag);
    chk({tag, " alu_w"}, alu_result_w, 32'h0);
    chk({tag, " rd_w"}, read_data_w, 32'h0);
    chk({tag, " pc4_w"}, pc_plus4_w, 32'h0);
    chk({tag, " wa_w"}, {27'h0, write_addr_w}, 32'h0);
    chk({tag, " rw_w"}, {31'h0, reg_write_w}, 32'h0);
    chk({tag, " rs_w"}, {30'h0, result_src_w}, 32'h0);
    chk({tag, " result_w"}, result_w, 32'h0);
    chk({tag, " timeout"}, {31'h0, mem_timeout}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

  initial begin
    int stalls;
    // alu wd pc4 wa rw rs mw ack rd | req we addr result rd_w rw_w wa_w
    vecs[0] = '{32'h10, 32'h0, 32'h4, 5'd5, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0,
                1'b0, 1'b0, 32'h10, 32'h10, 32'h0, 1'b1, 5'd5};
    vecs[1] = '{32'h103, 32'h0, 32'h8, 5'd7, 1'b1, 2'b01, 1'b0, 1'b1, 32'hDEADBEEF,
                1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 5'd7};
    vecs[2] = '{32'h20, 32'h0, 32'h44, 5'd1, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0,
                1'b0, 1'b0, 32'h20, 32'h44, 32'h0, 1'b1, 5'd1};
    vecs[3] = '{32'hABC, 32'h0, 32'h8, 5'd2, 1'b1, 2'b11, 1'b0, 1'b0, 32'h0,
                1'b0, 1'b0, 32'hAB8, 32'hABC, 32'h0, 1'b1, 5'd2};
    vecs[4] = '{32'h207, 32'h1234, 32'hC, 5'd0, 1'b0, 2'b00, 1'b1, 1'b1, 32'hFFFF,
                1'b1, 1'b1, 32'h204, 32'h207, 32'h0, 1'b0, 5'd0};
    vecs[5] = '{32'h30, 32'h55, 32'h10, 5'd3, 1'b1, 2'b01, 1'b1, 1'b1, 32'h5555,
                1'b1, 1'b1, 32'h30, 32'h0, 32'h0, 1'b1, 5'd3};
    vecs[6] = '{32'h9, 32'h0, 32'h14, 5'd4, 1'b1, 2'b00, 1'b0, 1'b1, 32'h777,
                1'b0, 1'b0, 32'h8, 32'h9, 32'h0, 1'b1, 5'd4};

    reset = 1'b1;
    nop();
    tick(); tick();
    reset = 1'b0;
    chk_wb_zero("reset");
    #1;
    chk("reset req", {31'h0, dmem_req}, 32'h0);
    chk("reset stall", {31'h0, stall_m}, 32'h0);

    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].alu, vecs[i].wd, vecs[i].pc4, vecs[i].wa, vecs[i].rw, vecs[i].rs,
            vecs[i].mw, vecs[i].ack, vecs[i].rd);
      #1;
      chk($sformatf("v%0d req", i), {31'h0, dmem_req}, {31'h0, vecs[i].e_req});
      chk($sformatf("v%0d stall", i), {31'h0, stall_m}, 32'h0);
      if (vecs[i].e_req) begin
        chk($sformatf("v%0d we", i), {31'h0, dmem_we}, {31'h0, vecs[i].e_we});
        chk($sformatf("v%0d addr", i), dmem_addr, vecs[i].e_addr);
      end
      tick();
      chk($sformatf("v%0d result_w", i), result_w, vecs[i].e_res);
      chk($sformatf("v%0d rd_w", i), read_data_w, vecs[i].e_rdw);
      chk($sformatf("v%0d rw_w", i), {31'h0, reg_write_w}, {31'h0, vecs[i].e_rw});
      chk($sformatf("v%0d wa_w", i), {27'h0, write_addr_w}, {27'h0, vecs[i].e_wa});
    end

    // Store with ack on the 3rd cycle after entry; inputs scrambled while waiting.
    drive(32'h402, 32'hCAFEF00D, 32'h50, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, 32'h0);
    stalls = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) dmem_ack = 1'b1;
      #1;
      if (stall_m) stalls++;
      chk($sformatf("st c%0d req", c), {31'h0, dmem_req}, 32'h1);
      chk($sformatf("st c%0d we", c), {31'h0, dmem_we}, 32'h1);
      chk($sformatf("st c%0d addr", c), dmem_addr, 32'h400);
      chk($sformatf("st c%0d wdata", c), dmem_wdata, 32'hCAFEF00D);
      tick();
      chk($sformatf("st c%0d rw_w", c), {31'h0, reg_write_w}, 32'h0);
      if (c == 0) drive(32'hFFFF_FFF0, 32'h1111_2222, 32'h0, 5'd31, 1'b1, 2'b01, 1'b0, 1'b0, 32'h0);
    end
    chk("st stalls", stalls, 32'd3);
    chk("st result_w", result_w, 32'h402);

    // Load that is never acknowledged: 4 stall cycles then abort.
    drive(32'h500, 32'h0, 32'h60, 5'd9, 1'b1, 2'b01, 1'b0, 1'b0, 32'h0);
    stalls = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (!stall_m) break;
      stalls++;
      tick();
    end
    chk("to stalls", stalls, 32'd4);
    chk("to abort req", {31'h0, dmem_req}, 32'h1);
    chk("to abort timeout", {31'h0, mem_timeout}, 32'h0);
    tick();
    chk("to rw_w", {31'h0, reg_write_w}, 32'h0);
    chk("to rd_w", read_data_w, 32'h0);
    chk("to wa_w", {27'h0, write_addr_w}, 32'd9);
    chk("to timeout", {31'h0, mem_timeout}, 32'h1);
    drive(32'h77, 32'h0, 32'h0, 5'd6, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0);
    #1;
    chk("to alu stall", {31'h0, stall_m}, 32'h0);
    tick();
    chk("to alu result", result_w, 32'h77);
    chk("to alu rw_w", {31'h0, reg_write_w}, 32'h1);
    chk("to sticky", {31'h0, mem_timeout}, 32'h1);

    // Reset during the 2nd WAIT cycle, then a late ack.
    drive(32'h600, 32'h0, 32'h64, 5'd8, 1'b1, 2'b01, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    nop();
    dmem_ack = 1'b1;
    dmem_rdata = 32'h999;
    #1;
    chk("rst req", {31'h0, dmem_req}, 32'h0);
    chk("rst stall", {31'h0, stall_m}, 32'h0);
    chk_wb_zero("rst");
    tick();
    chk("rst late rd_w", read_data_w, 32'h0);
    chk("rst late rw_w", {31'h0, reg_write_w}, 32'h0);

    // Back-to-back loads, one wait cycle each.
    drive(32'h700, 32'h0, 32'h0, 5'd3, 1'b1, 2'b01, 1'b0, 1'b0, 32'h0);
    #1;
    chk("b2b A stall", {31'h0, stall_m}, 32'h1);
    tick();
    chk("b2b A bubble", {31'h0, reg_write_w}, 32'h0);
    dmem_ack = 1'b1; dmem_rdata = 32'hA1;
    #1;
    chk("b2b A ack stall", {31'h0, stall_m}, 32'h0);
    tick();
    chk("b2b A rd_w", read_data_w, 32'hA1);
    chk("b2b A wa_w", {27'h0, write_addr_w}, 32'd3);
    chk("b2b A rw_w", {31'h0, reg_write_w}, 32'h1);
    drive(32'h704, 32'h0, 32'h0, 5'd4, 1'b1, 2'b01, 1'b0, 1'b0, 32'h0);
    #1;
    chk("b2b B req", {31'h0, dmem_req}, 32'h1);
    chk("b2b B addr", dmem_addr, 32'h704);
    chk("b2b B stall", {31'h0, stall_m}, 32'h1);
    tick();
    chk("b2b B bubble", {31'h0, reg_write_w}, 32'h0);
    dmem_ack = 1'b1; dmem_rdata = 32'hB2;
    tick();
    chk("b2b B rd_w", read_data_w, 32'hB2);
    chk("b2b B wa_w", {27'h0, write_addr_w}, 32'd4);
    chk("b2b B rw_w", {31'h0, reg_write_w}, 32'h1);
    nop();
    tick();
    chk("b2b no dup rw_w", {31'h0, reg_write_w}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline MEM stage of the RISC-V pipelined processor. It consumes the EX/MEM register outputs, performs the word load or store over a valid/ack data-memory handshake, and holds the MEM/WB pipeline register plus the writeback result mux. If memory does not acknowledge in the same cycle, it freezes the upstream pipeline through `stall_m`. It aborts any access that exceeds a bounded wait and raises a sticky error.

## Interface
- `MAX_WAIT`, default 15: maximum number of wait cycles before the access is aborted; must be ≥1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `alu_result_m`  in  32  ALU result; used as the memory address and the ALU writeback value.
- `wr_data_m`  in  32  store data.
- `pc_plus4_m`  in  32  PC+4, carried to writeback.
- `write_addr_m`  in  5  destination register index.
- `reg_write_m`  in  1  register write enable.
- `result_src_m`  in  2  result select: 00 = ALU, 01 = memory, 10 = PC+4, 11 = ALU.
- `mem_write_m`  in  1  store enable.
- `dmem_req`  out  1  memory request valid.
- `dmem_we`  out  1  1 = store, 0 = load.
- `dmem_addr`  out  32  word address, `{addr[31:2], 2'b00}`.
- `dmem_wdata`  out  32  store data.
- `dmem_ack`  in  1  request accepted/completed; load data is valid in the same cycle.
- `dmem_rdata`  in  32  load data.
- `stall_m`  out  1  freezes the F/D/E/M registers while high.
- `alu_result_w`, `read_data_w`, `pc_plus4_w`  out  32 each  MEM/WB register fields.
- `write_addr_w`  out  5  MEM/WB register field.
- `reg_write_w`  out  1  MEM/WB register field.
- `result_src_w`  out  2  MEM/WB register field.
- `result_w`  out  32  combinational mux of the MEM/WB fields selected by `result_src_w` (11 selects ALU).
- `mem_timeout`  out  1  sticky abort flag.

## Operation
- Memory op: `mem_write_m` = 1, or `result_src_m` = 01. If both are set, the access is a store; load data is discarded and `read_data_w` = 0.
- Two states, IDLE and WAIT.
- IDLE, no memory op:
  - `dmem_req` = 0, `stall_m` = 0.
  - MEM/WB loads the EX/MEM fields with `read_data_w` = 0.
- IDLE, memory op:
  - `dmem_req` = 1; address, data and `we` are driven combinationally from the inputs.
  - Request fields and control fields are captured into holding registers.
  - If `dmem_ack` is high: complete this cycle, `stall_m` = 0, MEM/WB loads (including `dmem_rdata` for a load), stay in IDLE.
  - Otherwise: `stall_m` = 1, MEM/WB loads a bubble, go to WAIT with wait count = 1.
- WAIT:
  - `dmem_req` = 1, with address, data and `we` taken from the holding registers. The inputs are ignored.
  - `dmem_ack` high: `stall_m` = 0, MEM/WB loads the held fields plus `dmem_rdata`, go to IDLE.
  - No ack and count < `MAX_WAIT`: `stall_m` = 1, bubble, increment count.
  - No ack and count = `MAX_WAIT`: abort, `stall_m` = 0. MEM/WB loads the held fields with `reg_write_w` forced to 0 and `read_data_w` = 0. Set `mem_timeout`, go to IDLE.
- Bubble: `reg_write_w` = 0, `result_src_w` = 00, all other fields 0.
- `dmem_ack` while `dmem_req` = 0 is ignored.
- Reset (synchronous, priority over everything, including mid-WAIT):
  - All MEM/WB outputs 0, `mem_timeout` = 0, state IDLE, count 0, holding registers 0.
  - `dmem_req` is low in the cycle after the reset edge; any outstanding access is abandoned.

## Timing
- Non-memory op, or zero-wait access: 1-cycle latency M→W, identical to a plain register; no stall.
- Access entering at cycle t with ack at t+k (k ≥ 1): `stall_m` is high in cycles t … t+k−1, which is k stall cycles. MEM/WB updates at the end of t+k.
- Timeout: no ack through cycle t+`MAX_WAIT`. That cycle aborts with `stall_m` low, giving `MAX_WAIT` stall cycles in total. `mem_timeout` reads 1 from t+`MAX_WAIT`+1 onward.
- The wait counter is `$clog2(MAX_WAIT+1)` bits wide and never wraps.
- `dmem_req` stays high continuously from cycle t to the ack or abort cycle. Address, data and `we` remain stable throughout.
- The cycle after completion accepts a new memory op. Back-to-back accesses therefore have no idle gap.

## Structure
- Package `mem_stage_pkg` contains:
  - the state enum `mem_state_t` (`MS_IDLE`, `MS_WAIT`);
  - constants `RS_ALU` = 2'b00, `RS_MEM` = 2'b01, `RS_PC4` = 2'b10.
- Sub-module `mem_wb_register`: flops only, with a load-fields path, a bubble path and synchronous reset. `memory_stage` holds the FSM, counter, holding registers, memory drive and `result_w` mux.

## Test plan
- ALU op (`alu_result_m` = 0x10, `reg_write_m` = 1, `result_src_m` = 00, `write_addr_m` = 5) → next cycle `result_w` = 0x10, `write_addr_w` = 5, `reg_write_w` = 1, `dmem_req` never high.
- Zero-wait load at address 0x103 with `dmem_ack` = 1 and rdata 0xDEADBEEF in the same cycle → `dmem_addr` = 0x100, no stall, next cycle `result_w` = 0xDEADBEEF.
- Store, ack after 3 cycles (k = 3) → `stall_m` high for exactly 3 cycles, `dmem_we` = 1, address and data stable, `reg_write_w` = 0 throughout.
- Load with no ack, `MAX_WAIT` = 4 → 4 stall cycles, then abort: `reg_write_w` = 0, `mem_timeout` = 1 and staying 1; the next ALU op passes normally.
- Reset asserted in the 2nd WAIT cycle → next cycle `dmem_req` = 0, `stall_m` = 0, all outputs 0, `mem_timeout` = 0. A late `dmem_ack` is ignored.
- Back-to-back loads with 1 wait each → each load gives 1 stall cycle and the correct `read_data_w`, with no lost or duplicated writeback.
